world_map_rd_arbiter: RTL and testbench

- Shares the single world-map BRAM read port between two requesters: the Rojobot sensor/location logic (requester 0) and the map-overlay/debug reader (requester 1).
- Arbitrates round-robin and issues at most one read per cycle.
- Tracks in-flight reads through a tag pipeline matched to the fixed map read latency, and returns each 2-bit pixel to the requester that issued it, in issue order.
- Sits between the requesters and the world-map port feeding the pixel delay stage.

---
 rtl/world_map_rd_arbiter.sv | 95 +++++++++
 tb/tb_world_map_rd_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/world_map_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : world_map_rd_arbiter
// Function : Round-robin share of the world-map read port between two
//            requesters, with in-order pixel return via a latency-matched
//            tag pipeline. Define WMAP_FIXED_PRIO_EN for fixed priority
//            (requester 0 always wins a conflict).
// Revision : 1.0  initial release
// ============================================================================
module world_map_rd_arbiter #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [1:0]        rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [1:0]        rdata1,
  output logic [ADDR_W-1:0] map_addr,
  output logic              map_en,
  input  logic [1:0]        map_dout
);

  localparam int C_TAG_LAST = RD_LAT;

  logic              r_last_gnt;
  logic [RD_LAT:0]   r_tag_vld;
  logic [RD_LAT:0]   r_tag_id;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_accept;
  logic              w_ret0;
  logic              w_ret1;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
`ifdef WMAP_FIXED_PRIO_EN
    w_gnt0 = req0;
    w_gnt1 = req1 & ~req0;
`else
    if (req0 && req1) begin
      w_gnt0 = r_last_gnt;
      w_gnt1 = ~r_last_gnt;
    end else begin
      w_gnt0 = req0;
      w_gnt1 = req1;
    end
`endif
  end

  assign gnt0     = w_gnt0;
  assign gnt1     = w_gnt1;
  assign w_accept = w_gnt0 | w_gnt1;

  // Tag entry 0 is loaded together with map_addr, so entry RD_LAT is the one
  // whose read data is present on map_dout during the current cycle.
  assign w_ret0 = r_tag_vld[C_TAG_LAST] & ~r_tag_id[C_TAG_LAST];
  assign w_ret1 = r_tag_vld[C_TAG_LAST] &  r_tag_id[C_TAG_LAST];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      map_addr   <= '0;
      map_en     <= 1'b0;
      r_last_gnt <= 1'b1;
      r_tag_vld  <= '0;
      r_tag_id   <= '0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= 2'b00;
      rdata1     <= 2'b00;
    end else begin
      map_en    <= w_accept;
      r_tag_vld <= {r_tag_vld[RD_LAT-1:0], w_accept};
      r_tag_id  <= {r_tag_id[RD_LAT-1:0], w_gnt1};
      if (w_accept) begin
        map_addr   <= w_gnt1 ? addr1 : addr0;
        r_last_gnt <= w_gnt1;
      end
      rvalid0 <= w_ret0;
      rvalid1 <= w_ret1;
      if (w_ret0) rdata0 <= map_dout;
      if (w_ret1) rdata1 <= map_dout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_world_map_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_world_map_rd_arbiter
// Function : Scoreboard bench for world_map_rd_arbiter (RD_LAT = 2).
// Revision : 1.0  initial release
// ============================================================================
module tb_world_map_rd_arbiter;

  localparam int ADDR_W = 14;
  localparam int RD_LAT = 2;
  localparam int C_RET  = RD_LAT + 2;

  logic              clk = 1'b0;
  logic              resetn;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              gnt0, gnt1, rvalid0, rvalid1, map_en;
  logic [1:0]        rdata0, rdata1, map_dout;
  logic [ADDR_W-1:0] map_addr;

  world_map_rd_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .map_addr(map_addr), .map_en(map_en), .map_dout(map_dout)
  );

  always #5 clk = ~clk;

  // Map model: data appears RD_LAT cycles after map_addr changes.
  logic [ADDR_W-1:0] r_dly [RD_LAT];
  always @(posedge clk) begin
    r_dly[0] <= map_addr;
    for (int i = 1; i < RD_LAT; i++) r_dly[i] <= r_dly[i-1];
  end
  assign map_dout = r_dly[RD_LAT-1][1:0] ^ r_dly[RD_LAT-1][5:4];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       id;
    logic [1:0] data;
    int         due;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;
  logic [ADDR_W-1:0] exp_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: pops the scoreboard whenever a return pulse appears.
  always @(negedge clk) begin
    if (rvalid0 || rvalid1) begin
      check("rvalid_onehot", {31'd0, rvalid0 & rvalid1}, 32'd0);
      if (q.size() == 0) begin
        check("unexpected_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("ret_id", {31'd0, rvalid1}, {31'd0, e.id});
        check("ret_data", {30'd0, e.id ? rdata1 : rdata0}, {30'd0, e.data});
        check("ret_cycle", cyc, e.due);
      end
    end else if (q.size() > 0 && q[0].due < cyc) begin
      check("missing_rvalid", cyc, q[0].due);
      void'(q.pop_front());
    end
  end

  // One cycle of stimulus starting at a negedge; ends at the next negedge.
  task automatic step(input logic r0, input logic [ADDR_W-1:0] a0,
                      input logic r1, input logic [ADDR_W-1:0] a1,
                      input logic eg0, input logic eg1,
                      input logic [1:0] ed, input bit push);
    exp_t e;
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    #1;
    check("gnt0", {31'd0, gnt0}, {31'd0, eg0});
    check("gnt1", {31'd0, gnt1}, {31'd0, eg1});
    if (push && (eg0 || eg1)) begin
      e.id = eg1; e.data = ed; e.due = cyc + C_RET;
      q.push_back(e);
    end
    if (eg0) exp_addr = a0;
    else if (eg1) exp_addr = a1;
    @(negedge clk);
    check("map_en", {31'd0, map_en}, {31'd0, eg0 | eg1});
    check("map_addr", {18'd0, map_addr}, {18'd0, exp_addr});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_map_addr", {18'd0, map_addr}, 32'd0);
    check("rst_map_en",   {31'd0, map_en},   32'd0);
    check("rst_rvalid",   {30'd0, rvalid1, rvalid0}, 32'd0);
    check("rst_rdata",    {28'd0, rdata1, rdata0},   32'd0);
  endtask

  initial begin
    resetn = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    resetn = 1'b1;

    // Single read from requester 0: 0x0102 -> pixel 2'b10.
    step(1'b1, 14'h0102, 1'b0, 14'h0000, 1'b1, 1'b0, 2'b10, 1'b1);
    idle(5);

    // Back-to-back requester 1, addresses 0..4.
    for (int i = 0; i < 5; i++)
      step(1'b0, 14'h0000, 1'b1, 14'(i), 1'b0, 1'b1, 2'(i), 1'b1);
    idle(5);

`ifdef WMAP_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++)
      step(1'b1, 14'h0010, 1'b1, 14'h0020, 1'b1, 1'b0, 2'b01, 1'b1);
    step(1'b0, 14'h0010, 1'b1, 14'h0020, 1'b0, 1'b1, 2'b10, 1'b1);
`else
    // Conflict: grants alternate 0,1,0,1 (last grant was requester 1).
    for (int i = 0; i < 4; i++)
      step(1'b1, 14'h0010, 1'b1, 14'h0020, (i % 2) == 0, (i % 2) == 1,
           ((i % 2) == 0) ? 2'b01 : 2'b10, 1'b1);
`endif
    idle(5);

    // Withdraw: requester 1 loses the conflict then drops its request.
    step(1'b1, 14'h0033, 1'b1, 14'h0011, 1'b1, 1'b0, 2'b00, 1'b1);
    idle(5);

    // Reset mid-flight: two accepted reads must never return.
    step(1'b1, 14'h0101, 1'b0, 14'h0000, 1'b1, 1'b0, 2'b01, 1'b0);
    step(1'b1, 14'h0102, 1'b0, 14'h0000, 1'b1, 1'b0, 2'b10, 1'b0);
    idle(1);
    resetn = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs();
    end
    resetn = 1'b1;
    exp_addr = '0;
    step(1'b1, 14'h0102, 1'b1, 14'h0021, 1'b1, 1'b0, 2'b10, 1'b1);
    idle(6);

    check("scoreboard_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
